// File: rtl/paquete_rv.sv
// rtl/paquete_rv.sv - shared type codes, opcodes and skid-buffer states for the RV immediate generator
package paquete_rv;

  localparam logic [2:0] TIPO_I       = 3'b000;
  localparam logic [2:0] TIPO_S       = 3'b001;
  localparam logic [2:0] TIPO_B       = 3'b010;
  localparam logic [2:0] TIPO_U       = 3'b011;
  localparam logic [2:0] TIPO_J       = 3'b100;
  localparam logic [2:0] TIPO_NINGUNO = 3'b101;
  localparam logic [2:0] TIPO_SHAMT   = 3'b110;
  localparam logic [2:0] TIPO_RES     = 3'b111;

  localparam logic [6:0] OP_CARGA   = 7'b0000011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_SISTEMA = 7'b1110011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_OP      = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [1:0] {
    VACIO = 2'd0,
    UNO   = 2'd1,
    LLENO = 2'd2
  } estado_t;

  // Register-immediate shifts carry a shift amount, not an I immediate.
  function automatic logic [2:0] tipo_de_opcode(input logic [6:0] opcode, input logic [2:0] funct3);
    logic [2:0] t;
    case (opcode)
      OP_CARGA, OP_JALR, OP_SISTEMA: t = TIPO_I;
      OP_IMM:    t = (funct3 == F3_SLL || funct3 == F3_SR) ? TIPO_SHAMT : TIPO_I;
      OP_STORE:  t = TIPO_S;
      OP_BRANCH: t = TIPO_B;
      OP_LUI, OP_AUIPC: t = TIPO_U;
      OP_JAL:    t = TIPO_J;
      OP_OP:     t = TIPO_NINGUNO;
      default:   t = TIPO_RES;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/extractor_inmediato_xlen.sv
// rtl/extractor_inmediato_xlen.sv - combinational inst/tipo to immediate, resolved type and illegal flag
module extractor_inmediato_xlen
  import paquete_rv::*;
#(
  parameter int XLEN      = 32,
  parameter bit MODO_AUTO = 1'b1
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      tipo,
  output logic [XLEN-1:0] inmediato,
  output logic [2:0]      tipo_resuelto,
  output logic            ilegal
);

  logic [XLEN-1:0] shamt;

  assign tipo_resuelto = MODO_AUTO ? tipo_de_opcode(inst[6:0], inst[14:12]) : tipo;
  assign ilegal        = (tipo_resuelto == TIPO_RES);

  // RV64 shifts use a 6-bit amount; RV32 ignores inst[25].
  generate
    if (XLEN == 64) begin : g_shamt64
      assign shamt = {{(XLEN-6){1'b0}}, inst[25:20]};
    end else begin : g_shamt32
      assign shamt = {{(XLEN-5){1'b0}}, inst[24:20]};
    end
  endgenerate

  always_comb begin
    inmediato = '0;
    case (tipo_resuelto)
      TIPO_I:     inmediato = {{(XLEN-12){inst[31]}}, inst[31:20]};
      TIPO_S:     inmediato = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      TIPO_B:     inmediato = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      TIPO_U:     inmediato = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
      TIPO_J:     inmediato = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      TIPO_SHAMT: inmediato = shamt;
      default:    inmediato = '0;
    endcase
  end

endmodule

// File: rtl/generador_inmediato_seg.sv
// rtl/generador_inmediato_seg.sv - registered immediate generator behind a 2-entry skid buffer
module generador_inmediato_seg
  import paquete_rv::*;
#(
  parameter int XLEN       = 32,
  parameter bit MODO_AUTO  = 1'b1,
  parameter int ANCHO_CONT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           inst,
  input  logic [2:0]            tipo,
  input  logic                  valido_ent,
  output logic                  listo_ent,
  output logic [XLEN-1:0]       inmediato,
  output logic [2:0]            tipo_sal,
  output logic                  ilegal,
  output logic                  valido_sal,
  input  logic                  listo_sal,
  output logic [ANCHO_CONT-1:0] cuenta_ilegal
);

  logic [XLEN-1:0] ext_inmediato;
  logic [2:0]      ext_tipo;
  logic            ext_ilegal;

  logic [XLEN-1:0] skid_inmediato;
  logic [2:0]      skid_tipo;
  logic            skid_ilegal;

  estado_t estado, estado_sig;
  logic    fuera_reset;
  logic    acepta, entrega;
  logic    carga_sal, carga_skid, mover_skid;

  extractor_inmediato_xlen #(
    .XLEN      (XLEN),
    .MODO_AUTO (MODO_AUTO)
  ) u_extractor (
    .inst          (inst),
    .tipo          (tipo),
    .inmediato     (ext_inmediato),
    .tipo_resuelto (ext_tipo),
    .ilegal        (ext_ilegal)
  );

  // fuera_reset keeps listo_ent low for as long as rst_n is held.
  assign listo_ent  = fuera_reset && (estado != LLENO);
  assign valido_sal = (estado != VACIO);
  assign acepta     = valido_ent && listo_ent;
  assign entrega    = valido_sal && listo_sal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado      <= VACIO;
      fuera_reset <= 1'b0;
    end else begin
      estado      <= estado_sig;
      fuera_reset <= 1'b1;
    end
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      VACIO: if (acepta) estado_sig = UNO;
      UNO: begin
        if (acepta && !entrega)      estado_sig = LLENO;
        else if (!acepta && entrega) estado_sig = VACIO;
      end
      LLENO: if (entrega) estado_sig = UNO;
      default: estado_sig = VACIO;
    endcase
  end

  always_comb begin
    carga_sal  = 1'b0;
    carga_skid = 1'b0;
    mover_skid = 1'b0;
    case (estado)
      VACIO: carga_sal = acepta;
      UNO: begin
        carga_sal  = acepta && entrega;
        carga_skid = acepta && !entrega;
      end
      LLENO:   mover_skid = entrega;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inmediato      <= '0;
      tipo_sal       <= TIPO_I;
      ilegal         <= 1'b0;
      skid_inmediato <= '0;
      skid_tipo      <= TIPO_I;
      skid_ilegal    <= 1'b0;
      cuenta_ilegal  <= '0;
    end else begin
      if (carga_sal) begin
        inmediato <= ext_inmediato;
        tipo_sal  <= ext_tipo;
        ilegal    <= ext_ilegal;
      end else if (mover_skid) begin
        inmediato <= skid_inmediato;
        tipo_sal  <= skid_tipo;
        ilegal    <= skid_ilegal;
      end
      if (carga_skid) begin
        skid_inmediato <= ext_inmediato;
        skid_tipo      <= ext_tipo;
        skid_ilegal    <= ext_ilegal;
      end
      if (entrega && ilegal && (cuenta_ilegal != {ANCHO_CONT{1'b1}}))
        cuenta_ilegal <= cuenta_ilegal + 1'b1;
    end
  end

endmodule

// File: tb/tb_generador_inmediato_seg.sv
// tb/tb_generador_inmediato_seg.sv - self-checking bench for generador_inmediato_seg
module tb_generador_inmediato_seg;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  tipo;
    logic [31:0] imm_a;
    logic [2:0]  tipo_a;
    logic        il_a;
    logic [31:0] imm_m;
    logic [2:0]  tipo_m;
    logic        il_m;
    logic [63:0] imm_w;
  } vec_t;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic [2:0]  tipo = '0;
  logic        valido_ent = 1'b0;
  logic        listo_sal = 1'b0;

  logic        listo_ent_a, listo_ent_m, listo_ent_w;
  logic [31:0] inm_a, inm_m;
  logic [63:0] inm_w;
  logic [2:0]  tipo_sal_a, tipo_sal_m, tipo_sal_w;
  logic        ilegal_a, ilegal_m, ilegal_w;
  logic        valido_sal_a, valido_sal_m, valido_sal_w;
  logic [7:0]  cuenta_a, cuenta_m, cuenta_w;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  vec_t tbl[NV];
  vec_t sb[$];
  vec_t cur_exp;
  vec_t e_pop;
  int   exp_cnt_a = 0;
  int   exp_cnt_m = 0;
  bit   hold_v = 0;
  logic [31:0] h_inm_a, h_inm_m;
  logic [63:0] h_inm_w;
  logic [2:0]  h_tipo_a;
  logic        h_il_a;
  bit   bp_done;

  generador_inmediato_seg #(.XLEN(32), .MODO_AUTO(1'b1), .ANCHO_CONT(8)) u_a (
    .clk(clk), .rst_n(rst_n), .inst(inst), .tipo(tipo), .valido_ent(valido_ent),
    .listo_ent(listo_ent_a), .inmediato(inm_a), .tipo_sal(tipo_sal_a), .ilegal(ilegal_a),
    .valido_sal(valido_sal_a), .listo_sal(listo_sal), .cuenta_ilegal(cuenta_a));

  generador_inmediato_seg #(.XLEN(32), .MODO_AUTO(1'b0), .ANCHO_CONT(8)) u_m (
    .clk(clk), .rst_n(rst_n), .inst(inst), .tipo(tipo), .valido_ent(valido_ent),
    .listo_ent(listo_ent_m), .inmediato(inm_m), .tipo_sal(tipo_sal_m), .ilegal(ilegal_m),
    .valido_sal(valido_sal_m), .listo_sal(listo_sal), .cuenta_ilegal(cuenta_m));

  generador_inmediato_seg #(.XLEN(64), .MODO_AUTO(1'b1), .ANCHO_CONT(8)) u_w (
    .clk(clk), .rst_n(rst_n), .inst(inst), .tipo(tipo), .valido_ent(valido_ent),
    .listo_ent(listo_ent_w), .inmediato(inm_w), .tipo_sal(tipo_sal_w), .ilegal(ilegal_w),
    .valido_sal(valido_sal_w), .listo_sal(listo_sal), .cuenta_ilegal(cuenta_w));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nombre, act, expv);
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [2:0] t,
                              input logic [31:0] ia, input logic [2:0] ta, input logic la,
                              input logic [31:0] im, input logic [2:0] tm, input logic lm,
                              input logic [63:0] iw);
    vec_t v;
    v.inst = i; v.tipo = t;
    v.imm_a = ia; v.tipo_a = ta; v.il_a = la;
    v.imm_m = im; v.tipo_m = tm; v.il_m = lm;
    v.imm_w = iw;
    return v;
  endfunction

  // Scoreboard: pop on output transfer, then push on input transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt_a = 0;
      exp_cnt_m = 0;
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valido", 64'(valido_sal_a), 64'd1);
        chk("hold_inm_a", 64'(inm_a), 64'(h_inm_a));
        chk("hold_tipo_a", 64'(tipo_sal_a), 64'(h_tipo_a));
        chk("hold_il_a", 64'(ilegal_a), 64'(h_il_a));
        chk("hold_inm_m", 64'(inm_m), 64'(h_inm_m));
        chk("hold_inm_w", inm_w, h_inm_w);
      end
      if (valido_sal_a && listo_sal) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          e_pop = sb.pop_front();
          chk("inm_a", 64'(inm_a), 64'(e_pop.imm_a));
          chk("tipo_a", 64'(tipo_sal_a), 64'(e_pop.tipo_a));
          chk("ilegal_a", 64'(ilegal_a), 64'(e_pop.il_a));
          chk("inm_m", 64'(inm_m), 64'(e_pop.imm_m));
          chk("tipo_m", 64'(tipo_sal_m), 64'(e_pop.tipo_m));
          chk("ilegal_m", 64'(ilegal_m), 64'(e_pop.il_m));
          chk("valido_m", 64'(valido_sal_m), 64'd1);
          chk("inm_w", inm_w, e_pop.imm_w);
          chk("tipo_w", 64'(tipo_sal_w), 64'(e_pop.tipo_a));
          chk("ilegal_w", 64'(ilegal_w), 64'(e_pop.il_a));
          chk("valido_w", 64'(valido_sal_w), 64'd1);
          chk("cuenta_a", 64'(cuenta_a), 64'(exp_cnt_a));
          chk("cuenta_m", 64'(cuenta_m), 64'(exp_cnt_m));
          chk("cuenta_w", 64'(cuenta_w), 64'(exp_cnt_a));
          if (e_pop.il_a && exp_cnt_a < 255) exp_cnt_a++;
          if (e_pop.il_m && exp_cnt_m < 255) exp_cnt_m++;
        end
      end
      hold_v = valido_sal_a && !listo_sal;
      h_inm_a = inm_a; h_tipo_a = tipo_sal_a; h_il_a = ilegal_a;
      h_inm_m = inm_m; h_inm_w = inm_w;
      if (valido_ent && listo_ent_a) sb.push_back(cur_exp);
    end
  end

  task automatic send(input vec_t v);
    bit ok = 0;
    inst = v.inst; tipo = v.tipo; cur_exp = v; valido_ent = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (listo_ent_a) ok = 1;
      @(posedge clk); #1;
    end
    valido_ent = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit ok = 0;
    listo_sal = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !valido_sal_a) ok = 1;
    end
    chk("drain", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic vec_t ilegal_vec();
    logic [31:0] r;
    r = $urandom() & 32'hFFFF_FF80;
    return mk(r, 3'b101, 32'h0, 3'b111, 1'b1, 32'h0, 3'b101, 1'b0, 64'h0);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    tbl[0]  = mk(32'h7D000013, 3'b000, 32'h000007D0, 3'b000, 0, 32'h000007D0, 3'b000, 0, 64'h00000000000007D0);
    tbl[1]  = mk(32'h83000013, 3'b000, 32'hFFFFF830, 3'b000, 0, 32'hFFFFF830, 3'b000, 0, 64'hFFFFFFFFFFFFF830);
    tbl[2]  = mk(32'hC4000463, 3'b010, 32'hFFFFF448, 3'b010, 0, 32'hFFFFF448, 3'b010, 0, 64'hFFFFFFFFFFFFF448);
    tbl[3]  = mk(32'hDC10B06F, 3'b100, 32'hFFF0BDC0, 3'b100, 0, 32'hFFF0BDC0, 3'b100, 0, 64'hFFFFFFFFFFF0BDC0);
    tbl[4]  = mk(32'h00064037, 3'b011, 32'h00064000, 3'b011, 0, 32'h00064000, 3'b011, 0, 64'h0000000000064000);
    tbl[5]  = mk(32'hFFF9C037, 3'b011, 32'hFFF9C000, 3'b011, 0, 32'hFFF9C000, 3'b011, 0, 64'hFFFFFFFFFFF9C000);
    tbl[6]  = mk(32'h01F09093, 3'b110, 32'h0000001F, 3'b110, 0, 32'h0000001F, 3'b110, 0, 64'h000000000000001F);
    tbl[7]  = mk(32'h03F09093, 3'b110, 32'h0000001F, 3'b110, 0, 32'h0000001F, 3'b110, 0, 64'h000000000000003F);
    tbl[8]  = mk(32'h12345600, 3'b101, 32'h00000000, 3'b111, 1, 32'h00000000, 3'b101, 0, 64'h0000000000000000);
    tbl[9]  = mk(32'h7D000013, 3'b111, 32'h000007D0, 3'b000, 0, 32'h00000000, 3'b111, 1, 64'h00000000000007D0);
    tbl[10] = mk(32'h00B50533, 3'b001, 32'h00000000, 3'b101, 0, 32'h0000000A, 3'b001, 0, 64'h0000000000000000);
    tbl[11] = mk(32'h40555513, 3'b000, 32'h00000005, 3'b110, 0, 32'h00000405, 3'b000, 0, 64'h0000000000000005);
    tbl[12] = mk(32'hFFF52503, 3'b011, 32'hFFFFFFFF, 3'b000, 0, 32'hFFF52000, 3'b011, 0, 64'hFFFFFFFFFFFFFFFF);
    tbl[13] = mk(32'hFE002E23, 3'b100, 32'hFFFFFFFC, 3'b001, 0, 32'hFFF027E0, 3'b100, 0, 64'hFFFFFFFFFFFFFFFC);
    tbl[14] = mk(32'h00001517, 3'b010, 32'h00001000, 3'b011, 0, 32'h0000000A, 3'b010, 0, 64'h0000000000001000);
    tbl[15] = mk(32'h00008067, 3'b101, 32'h00000000, 3'b000, 0, 32'h00000000, 3'b101, 0, 64'h0000000000000000);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valido", 64'(valido_sal_a), 64'd0);
    chk("rst_inm", 64'(inm_a), 64'd0);
    chk("rst_inm_w", inm_w, 64'd0);
    chk("rst_tipo", 64'(tipo_sal_a), 64'd0);
    chk("rst_ilegal", 64'(ilegal_a), 64'd0);
    chk("rst_cuenta", 64'(cuenta_a), 64'd0);
    chk("rst_listo_ent", 64'(listo_ent_a), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("listo_tras_reset", 64'(listo_ent_a), 64'd1);

    // one-cycle latency
    listo_sal = 1'b1;
    send(tbl[0]);
    @(negedge clk);
    chk("lat_valido", 64'(valido_sal_a), 64'd1);
    chk("lat_inm", 64'(inm_a), 64'h7D0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_vacio", 64'(valido_sal_a), 64'd0);
    @(posedge clk); #1;

    // full throughput over the whole table
    c0 = cyc;
    for (int i = 0; i < NV; i++) send(tbl[i]);
    chk("throughput", 64'(cyc - c0), 64'(NV));
    drain();

    // backpressure: listo_ent falls after the second unconsumed accept
    listo_sal = 1'b0;
    send(tbl[2]);
    chk("bp_listo_1", 64'(listo_ent_a), 64'd1);
    send(tbl[3]);
    chk("bp_listo_2", 64'(listo_ent_a), 64'd0);
    fork
      send(tbl[4]);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("bp_lleno", 64'(listo_ent_a), 64'd0);
        end
        listo_sal = 1'b1;
      end
    join
    send(tbl[5]);
    drain();

    // random backpressure and input gaps
    bp_done = 0;
    fork
      begin
        for (int r = 0; r < 3; r++)
          for (int i = 0; i < NV; i++) begin
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
            send(tbl[i]);
          end
        bp_done = 1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          listo_sal = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // illegal opcodes saturate the counter
    for (int i = 0; i < 300; i++) send(ilegal_vec());
    drain();
    chk("sat_cuenta_a", 64'(cuenta_a), 64'd255);
    chk("sat_cuenta_w", 64'(cuenta_w), 64'd255);
    chk("cuenta_m", 64'(cuenta_m), 64'(exp_cnt_m));

    // reset while LLENO drops both entries uncounted
    listo_sal = 1'b0;
    send(ilegal_vec());
    send(ilegal_vec());
    chk("lleno_antes_reset", 64'(listo_ent_a), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst2_valido", 64'(valido_sal_a), 64'd0);
    chk("rst2_cuenta", 64'(cuenta_a), 64'd0);
    chk("rst2_inm", 64'(inm_a), 64'd0);
    chk("rst2_listo_ent", 64'(listo_ent_a), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst2_listo_tras", 64'(listo_ent_a), 64'd1);
    chk("rst2_valido_tras", 64'(valido_sal_a), 64'd0);
    listo_sal = 1'b1;
    send(tbl[8]);
    drain();
    chk("rst2_cuenta_final", 64'(cuenta_a), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
